// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

  localparam int unsigned ROM_ADDR_W  = 5;
  localparam int unsigned ROM_WORDS   = 2 ** ROM_ADDR_W;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned FETCH_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer built as a shift register so the head is always a flop.
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t tail, head_nxt, tail_nxt;
  logic [1:0]   count_nxt;

  // Flush wins over push/pop; a flush keeps stale data but drops the count.
  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_nxt = din;
          else               tail_nxt = din;
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          head_nxt  = tail;
          count_nxt = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_nxt = din;
          end else begin
            head_nxt = tail;
            tail_nxt = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
      valid <= 1'b0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      valid <= (count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM and feeds decode
// through a 2-entry buffer with redirect, halt and a delivered-instruction count.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = ROM_ADDR_W,
  parameter int unsigned     DATA_W   = INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     CNT_W    = FETCH_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              redirect, push, pop, accept;
  logic [1:0]        count;
  fetch_entry_t      din, head;

  assign rom_addr  = pc[ADDR_W+1:2];
  assign din       = '{pc: pc, instr: rom_data};
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .valid (out_valid),
    .count (count)
  );

  // A halt request in RUN also suppresses the fetch of that same cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = fetch_cnt;
    push      = 1'b0;
    redirect  = redirect_valid && (state != IDLE);
    pop       = out_valid && out_ready;
    accept    = pop && !redirect;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        push = !redirect && !halt_req &&
               ((count < 2'd2) || ((count == 2'd2) && out_ready));
        if (halt_req) state_nxt = HALT;
      end
      HALT: if (redirect && !halt_req) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (redirect)  pc_nxt = redirect_pc & ~PC_W'(32'h3);
    else if (push) pc_nxt = pc + PC_W'(INSTR_BYTES);
    if (accept)    cnt_nxt = fetch_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      halted    <= (state_nxt == HALT);
      fetch_cnt <= cnt_nxt;
    end
  end

endmodule
